tlb_op_sequencer: RTL
=====================

// Module: tlb_op_sequencer
// PURPOSE
//  Multi-cycle controller for TLB maintenance instructions (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
//  Sits between WB-stage instruction issue and the TLB array + CSR file. Sequences the TLB
//  search/read/write ports and strobes the CSR capture enables (s1e, re). Owns the TLBFILL
//  round-robin index and walks all entries for INVTLB. Signals done and refetch to the pipeline.
// PARAMETERS
//  TLBNUM      16             number of TLB entries (power of 2)
//  IDX_W       $clog2(TLBNUM) index width; matches TLBNUMSIZE
// PORTS
//  clk          in   1      clock
//  resetn       in   1      asynchronous, active-low reset
//  op_valid     in   1      TLB instruction request
//  op_ready     out  1      sequencer idle; request accepted when op_valid&op_ready
//  op_type      in   3      0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 reserved (treated as bad)
//  inv_op       in   5      INVTLB op field
//  inv_asid     in   10     INVTLB rj asid
//  inv_vppn     in   19     INVTLB rk va[31:13]
//  csr_index    in   IDX_W  TLBIDX.index
//  csr_vppn     in   19     TLBEHI.vppn
//  csr_asid     in   10     ASID.asid
//  s_req        out  1      TLB search-port request (vppn=csr_vppn, asid=csr_asid)
//  s_found      in   1      search hit, valid cycle after s_req
//  s_index      in   IDX_W  hit index, valid with s_found
//  csr_s1e      out  1      CSR capture of search result
//  csr_s1_index out  IDX_W  index to CSR
//  csr_s1_ne    out  1      ~s_found
//  rd_en        out  1      TLB read-port enable
//  rd_index     out  IDX_W  read index
//  rd_e,rd_g    in   1,1    entry E / G, valid cycle after rd_en
//  rd_asid      in   10     entry asid
//  rd_vppn      in   19     entry vppn
//  rd_ps        in   6      entry page size (12 or 21)
//  csr_re       out  1      CSR capture of read data
//  we           out  1      TLB write enable
//  w_index      out  IDX_W  write index
//  w_clr_e      out  1      with we: clear E only (INV); else full write from CSR
//  op_done      out  1      one-cycle completion pulse
//  refetch      out  1      one-cycle, with op_done; redirect to pc+4 and flush fetch
//  inv_bad      out  1      one-cycle, with op_done; illegal inv_op/op_type -> INE
// BEHAVIOUR
//  Reset (async, any state): state IDLE, fill_ctr=0, walk_idx=0, all outputs 0 except op_ready=1.
//  All strobes are registered one-cycle pulses. op_ready=(state==IDLE); op_valid ignored otherwise.
//  States: IDLE, SRCH, RD, WR, INV_RD, INV_CMP, DONE.
//  - SRCH: accept cycle T -> s_req=1 at T+1; T+2 csr_s1e=1, index/ne from s_found/s_index
//    (index=0 when miss); T+3 op_done/refetch. Entry: SRCH->DONE.
//  - RD: T+1 rd_en, rd_index=csr_index; T+2 csr_re=1; T+3 op_done. Entry stays valid even if rd_e=0.
//  - WR/FILL: T+1 we=1, w_clr_e=0; w_index=csr_index (WR) or fill_ctr sampled at T (FILL);
//    T+2 op_done.
//  - fill_ctr: free-running +1 every cycle, wraps TLBNUM-1 -> 0.
//  - INV: legal inv_op 0..6 else T+1 op_done+inv_bad, refetch=0, no TLB access.
//    Walk walk_idx 0..TLBNUM-1: INV_RD rd_en(walk_idx); INV_CMP evaluate match, we+w_clr_e on
//    match&rd_e, then walk_idx+1. After last entry -> DONE. Total 2*TLBNUM+2 cycles from accept.
//    vmatch: ps==21 ? rd_vppn[18:9]==inv_vppn[18:9] : rd_vppn==inv_vppn. amatch: rd_asid==inv_asid.
//    op0,1 all; 2 G=1; 3 G=0; 4 G=0&amatch; 5 G=0&amatch&vmatch; 6 (G|amatch)&vmatch.
//  - DONE: op_done=1, refetch=~bad, return IDLE; op_ready=1 next cycle.
//  - Reset mid-walk: partial invalidation stands; no op_done emitted.
//  - we and rd_en are never asserted to the same index in one cycle.
// TESTING
//  reset low mid-INV walk -> next cycle IDLE, op_ready=1, no op_done, fill_ctr=0
//  SRCH, TLB hit idx 5 -> csr_s1e at T+2, csr_s1_index=5, ne=0; miss -> ne=1; op_done+refetch T+3
//  FILL at fill_ctr=15 -> we, w_index=15, w_clr_e=0; next FILL wraps through 0
//  INV op=5 asid=3 vppn=0x100, entries {0:G0 asid3 vppn0x100, 1:G1 same, 2:G0 asid4} -> only idx0 cleared,
//    op_done at T+34 (TLBNUM=16)
//  INV op=6, ps=21 entry vppn 0x1FF, inv_vppn 0x1C0, G=1 -> cleared (upper 10 bits match)
//  INV op=7 -> T+1 op_done, inv_bad=1, refetch=0, no rd_en/we

Source files
------------

// File: rtl/tlb_op_sequencer.sv
// Multi-cycle sequencer for the TLB maintenance instructions (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Drives the TLB search/read/write ports and CSR capture strobes; every strobe is a registered pulse.
module tlb_op_sequencer #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_type,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_vppn,
    input  logic [IDX_W-1:0] csr_index,
    input  logic [18:0]      csr_vppn,
    input  logic [9:0]       csr_asid,
    output logic             s_req,
    input  logic             s_found,
    input  logic [IDX_W-1:0] s_index,
    output logic             csr_s1e,
    output logic [IDX_W-1:0] csr_s1_index,
    output logic             csr_s1_ne,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_index,
    input  logic             rd_e,
    input  logic             rd_g,
    input  logic [9:0]       rd_asid,
    input  logic [18:0]      rd_vppn,
    input  logic [5:0]       rd_ps,
    output logic             csr_re,
    output logic             we,
    output logic [IDX_W-1:0] w_index,
    output logic             w_clr_e,
    output logic             op_done,
    output logic             refetch,
    output logic             inv_bad
);

    typedef enum logic [2:0] {IDLE, SRCH, RD, WR, INV_RD, INV_CMP, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] fill_ctr, walk_idx, walk_nxt;
    logic [4:0]       inv_op_q;
    logic [9:0]       inv_asid_q;
    logic [18:0]      inv_vppn_q;
    logic             accept;
    logic             vmatch, amatch, sel, inv_hit;

    logic             s_req_n, s1e_n, rd_en_n, re_n, we_n, clr_n, done_n, refetch_n, bad_n;
    logic [IDX_W-1:0] rd_index_n, w_index_n;

    assign op_ready     = (state == IDLE);
    assign accept       = op_valid & op_ready;
    // Search port answers combinationally in the cycle csr_s1e is high.
    assign csr_s1_index = (csr_s1e && s_found) ? s_index : '0;
    assign csr_s1_ne    = csr_s1e & ~s_found;

    // Match evaluation on the entry returned by the previous INV_RD read.
    always_comb begin
        vmatch = (rd_ps == 6'd21) ? (rd_vppn[18:9] == inv_vppn_q[18:9]) : (rd_vppn == inv_vppn_q);
        amatch = (rd_asid == inv_asid_q);
        case (inv_op_q)
            5'd0, 5'd1: sel = 1'b1;
            5'd2:       sel = rd_g;
            5'd3:       sel = ~rd_g;
            5'd4:       sel = ~rd_g & amatch;
            5'd5:       sel = ~rd_g & amatch & vmatch;
            5'd6:       sel = (rd_g | amatch) & vmatch;
            default:    sel = 1'b0;
        endcase
        inv_hit = sel & rd_e;
    end

    always_comb begin
        state_nxt  = state;
        walk_nxt   = walk_idx;
        s_req_n    = 1'b0;
        s1e_n      = 1'b0;
        rd_en_n    = 1'b0;
        re_n       = 1'b0;
        we_n       = 1'b0;
        clr_n      = 1'b0;
        done_n     = 1'b0;
        refetch_n  = 1'b0;
        bad_n      = 1'b0;
        rd_index_n = rd_index;
        w_index_n  = w_index;
        case (state)
            IDLE: if (op_valid) begin
                case (op_type)
                    3'd0: begin state_nxt = SRCH; s_req_n = 1'b1; end
                    3'd1: begin state_nxt = RD; rd_en_n = 1'b1; rd_index_n = csr_index; end
                    3'd2: begin state_nxt = WR; we_n = 1'b1; w_index_n = csr_index; end
                    3'd3: begin state_nxt = WR; we_n = 1'b1; w_index_n = fill_ctr; end
                    3'd4: begin
                        if (inv_op <= 5'd6) begin
                            state_nxt  = INV_RD;
                            rd_en_n    = 1'b1;
                            rd_index_n = '0;
                            walk_nxt   = '0;
                        end else begin
                            done_n = 1'b1;
                            bad_n  = 1'b1;
                        end
                    end
                    default: begin done_n = 1'b1; bad_n = 1'b1; end
                endcase
            end
            SRCH:   begin state_nxt = DONE; s1e_n = 1'b1; end
            RD:     begin state_nxt = DONE; re_n = 1'b1; end
            WR:     begin state_nxt = IDLE; done_n = 1'b1; refetch_n = 1'b1; end
            INV_RD: state_nxt = INV_CMP;
            INV_CMP: begin
                we_n      = inv_hit;
                clr_n     = inv_hit;
                w_index_n = walk_idx;
                if (walk_idx == IDX_W'(TLBNUM - 1)) begin
                    state_nxt = DONE;
                end else begin
                    // Next read overlaps this write but always targets walk_idx+1.
                    state_nxt  = INV_RD;
                    walk_nxt   = walk_idx + 1'b1;
                    rd_en_n    = 1'b1;
                    rd_index_n = walk_idx + 1'b1;
                end
            end
            DONE:    begin state_nxt = IDLE; done_n = 1'b1; refetch_n = 1'b1; end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            fill_ctr   <= '0;
            walk_idx   <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            s_req      <= 1'b0;
            csr_s1e    <= 1'b0;
            rd_en      <= 1'b0;
            rd_index   <= '0;
            csr_re     <= 1'b0;
            we         <= 1'b0;
            w_index    <= '0;
            w_clr_e    <= 1'b0;
            op_done    <= 1'b0;
            refetch    <= 1'b0;
            inv_bad    <= 1'b0;
        end else begin
            state    <= state_nxt;
            fill_ctr <= fill_ctr + 1'b1;
            walk_idx <= walk_nxt;
            if (accept) begin
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vppn_q <= inv_vppn;
            end
            s_req    <= s_req_n;
            csr_s1e  <= s1e_n;
            rd_en    <= rd_en_n;
            rd_index <= rd_index_n;
            csr_re   <= re_n;
            we       <= we_n;
            w_index  <= w_index_n;
            w_clr_e  <= clr_n;
            op_done  <= done_n;
            refetch  <= refetch_n;
            inv_bad  <= bad_n;
        end
    end

    // Search key comes straight from CSRs into the TLB; the sequencer only strobes it.
    logic unused_ok;
    assign unused_ok = ^{csr_vppn, csr_asid};

endmodule
